// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for the west edge of a ROW x COL mac_tile array.
//
// Each accepted job runs four phases. In LOAD it reads the weights (COL of them, or
// 2*COL in SIMD mode). In EXEC it reads len activation vectors. DRAIN then waits
// ROW+COL idle cycles so the partial sums reach the south edge. DONE is a one-cycle
// completion. The array instruction lags the SRAM read by one cycle, so it reaches
// the array in the same cycle as the data it describes.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      job request, only honoured in IDLE
//   clear      synchronous abort; in IDLE it also blocks a start
//   simd       job mode (1 = two weights per tile)
//   w_base     first weight address
//   x_base     first activation address
//   len        number of execute cycles
//   mem_rd_en  SRAM read enable
//   mem_addr   SRAM read address (holds its value when no read is issued)
//   inst_w     array instruction {simd, execute, load}, one cycle behind the read
//   busy       high whenever the sequencer is not idle
//   done       one-cycle completion pulse
module mac_array_ctrl #(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned ADDR_BW = 10,
    parameter int unsigned LEN_BW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               simd,
    input  logic [ADDR_BW-1:0] w_base,
    input  logic [ADDR_BW-1:0] x_base,
    input  logic [LEN_BW-1:0]  len,
    output logic               mem_rd_en,
    output logic [ADDR_BW-1:0] mem_addr,
    output logic [2:0]         inst_w,
    output logic               busy,
    output logic               done
);

    // A single phase counter serves all three multi-cycle phases. It must be wide
    // enough for the longest of them.
    localparam int unsigned PhW  = $clog2(2 * COL + ROW + 1);
    localparam int unsigned CntW = (PhW > LEN_BW) ? PhW : LEN_BW;

    localparam logic [CntW-1:0] LastLoadNorm = CntW'(COL - 1);
    localparam logic [CntW-1:0] LastLoadSimd = CntW'(2 * COL - 1);
    localparam logic [CntW-1:0] LastDrain    = CntW'(ROW + COL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExec,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               simd_q, simd_d;
    logic [ADDR_BW-1:0] w_base_q, w_base_d;
    logic [ADDR_BW-1:0] x_base_q, x_base_d;
    logic [LEN_BW-1:0]  len_q, len_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_BW-1:0] addr_q, addr_d;
    logic [2:0]         inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CntW-1:0]    cnt_inc;
    logic [CntW-1:0]    last_load;
    logic [CntW-1:0]    last_exec;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        simd_d   = simd_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        len_d    = len_q;
        rd_en_d  = rd_en_q;
        addr_d   = addr_q;
        inst_d   = 3'b000;

        cnt_inc   = cnt_q + CntW'(1);
        last_load = simd_q ? LastLoadSimd : LastLoadNorm;
        // Only used in EXEC, where len_q is known to be non-zero.
        last_exec = CntW'(len_q) - CntW'(1);

        unique case (state_q)
            StIdle: begin
                if (start && !clear) begin
                    state_d  = StLoad;
                    simd_d   = simd;
                    w_base_d = w_base;
                    x_base_d = x_base;
                    len_d    = len;
                    cnt_d    = '0;
                    rd_en_d  = 1'b1;
                    addr_d   = w_base;
                end
            end
            StLoad: begin
                if (cnt_q == last_load) begin
                    cnt_d = '0;
                    if (len_q != '0) begin
                        state_d = StExec;
                        rd_en_d = 1'b1;
                        addr_d  = x_base_q;
                    end else begin
                        state_d = StDone;
                        rd_en_d = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_inc;
                    addr_d = w_base_q + ADDR_BW'(cnt_inc);
                end
            end
            StExec: begin
                if (cnt_q == last_exec) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    rd_en_d = 1'b0;
                end else begin
                    cnt_d  = cnt_inc;
                    addr_d = x_base_q + ADDR_BW'(cnt_inc);
                end
            end
            StDrain: begin
                if (cnt_q == LastDrain) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                rd_en_d = 1'b0;
            end
        endcase

        // The instruction follows the current state, so it lines up with the data
        // the SRAM returns one cycle after the read was issued.
        if (state_q == StLoad) begin
            inst_d = {simd_q, 2'b01};
        end else if (state_q == StExec) begin
            inst_d = {simd_q, 2'b10};
        end

        // An abort drops the job at once. The instruction is cancelled too, so data
        // that is still in flight is never consumed.
        if (clear && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            rd_en_d = 1'b0;
            inst_d  = 3'b000;
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            simd_q   <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            len_q    <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            inst_q   <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            simd_q   <= simd_d;
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            len_q    <= len_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign inst_w    = inst_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
